// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, keeps one
// fetch outstanding on a req/ack bus, and absorbs decode stalls in a 1-entry skid.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    typedef enum logic [1:0] {
        S_RST,
        S_FETCH,
        S_KILL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_pc_q, target_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;

    logic        req;
    logic        ack;
    logic [31:0] redir_pc;

    assign req      = (state_q == S_FETCH && !skid_vld_q) || (state_q == S_KILL);
    assign ack      = req && imem_ack_i;
    assign redir_pc = redirect_pc_i & ~32'd3;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        target_pc_d  = target_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_vld_d   = ifid_vld_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    ifid_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (redirect_i) begin
                    ifid_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                    // Keep the bus address stable until the in-flight fetch is acked.
                    if (req && !ack) begin
                        target_pc_d = redir_pc;
                        state_d     = S_KILL;
                    end else begin
                        fetch_pc_d = redir_pc;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (!stall_i) begin
                        ifid_vld_d   = 1'b1;
                        ifid_instr_d = imem_rdata_i;
                        ifid_pc_d    = fetch_pc_q;
                    end else begin
                        skid_vld_d   = 1'b1;
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = fetch_pc_q;
                    end
                end else if (!stall_i) begin
                    // Decoder consumed the entry: refill from skid or insert a bubble.
                    ifid_vld_d = skid_vld_q;
                    if (skid_vld_q) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc_d    = skid_pc_q;
                        skid_vld_d   = 1'b0;
                    end
                end
            end
            S_KILL: begin
                ifid_vld_d = 1'b0;
                skid_vld_d = 1'b0;
                if (redirect_i) begin
                    target_pc_d = redir_pc;
                end
                if (ack) begin
                    state_d    = S_FETCH;
                    fetch_pc_d = redirect_i ? redir_pc : target_pc_q;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_RST;
            fetch_pc_q <= RESET_PC;
            skid_vld_q <= 1'b0;
            ifid_vld_q <= 1'b0;
            ifid_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            skid_vld_q <= skid_vld_d;
            ifid_vld_q <= ifid_vld_d;
            ifid_pc_q  <= ifid_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        target_pc_q  <= target_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
        ifid_instr_q <= ifid_instr_d;
    end

    assign imem_req_o  = req;
    assign imem_addr_o = fetch_pc_q;
    assign valid_o     = ifid_vld_q;
    assign instr_o     = ifid_vld_q ? ifid_instr_q : NOP;
    assign pc_o        = ifid_pc_q;
    assign pc_plus4_o  = ifid_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a PC-stream model predicts which
// fetched words reach decode, and a negedge monitor consumes IF/ID entries.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOPW   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    ent_t        mon_e;
    int          vectors     = 0;
    int          miscompares = 0;
    bit          mon_en      = 1'b0;

    // Architectural model: next useful fetch PC, plus the address of a fetch
    // issued before a redirect that must still complete and be discarded.
    logic [31:0] exp_pc;
    logic [31:0] stale_addr;
    bit          stale;
    bit          p_rst, p_stall, p_redir;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("pc_plus4", pc_plus4_o, pc_o + 32'd4);
            if (!valid_o) chk("nop_when_invalid", instr_o, NOPW);
            if (!rst_i) begin
                sb.delete();
            end else begin
                if (valid_o && !stall_i) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_instr: got pc %h, expected no valid entry at %0t", pc_o, $time);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("instr", instr_o, mon_e.instr);
                        chk("pc", pc_o, mon_e.pc);
                    end
                end
                if (redirect_i) sb.delete();
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] tpc, input bit a);
        bit req;
        @(posedge clk);
        #1;
        req = imem_req_o;
        if (!p_rst) begin
            chk("req_after_reset", 32'(imem_req_o), 32'd0);
            chk("valid_after_reset", 32'(valid_o), 32'd0);
            chk("pc_after_reset", pc_o, 32'd0);
        end else if (!p_stall) begin
            chk("req_live", 32'(imem_req_o), 32'd1);
        end
        if (p_redir) chk("valid_after_redirect", 32'(valid_o), 32'd0);
        if (req) chk("imem_addr", imem_addr_o, stale ? stale_addr : exp_pc);

        rst_i         = r;
        stall_i       = s;
        redirect_i    = rd;
        redirect_pc_i = tpc;
        imem_ack_i    = a;
        imem_rdata_i  = mem(imem_addr_o);

        if (!r) begin
            exp_pc = RST_PC;
            stale  = 1'b0;
        end else if (rd) begin
            if (req && !a && !stale) begin
                stale      = 1'b1;
                stale_addr = exp_pc;
            end else if (req && a) begin
                stale = 1'b0;
            end
            exp_pc = tpc & ~32'd3;
        end else if (req && a) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                sb.push_back('{pc: exp_pc, instr: mem(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
        p_rst   = r;
        p_stall = s;
        p_redir = rd;
    endtask

    initial begin
        bit          r, s, rd, a;
        logic [31:0] tpc;
        int          ack_pct;
        rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ack_i = 1'b0; imem_rdata_i = '0;
        exp_pc = RST_PC; stale_addr = '0; stale = 1'b0;
        p_rst = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            r = 1'b1; s = 1'b0; rd = 1'b0; a = 1'b1; tpc = '0;
            if (cyc < 4) begin
                r = 1'b0;
                a = 1'b0;
            end else if (cyc >= 24) begin
                case ((cyc / 256) % 4)
                    0:       ack_pct = 100;
                    1:       ack_pct = 60;
                    2:       ack_pct = 30;
                    default: ack_pct = 85;
                endcase
                r  = ($urandom_range(0, 299) != 0);
                s  = ($urandom_range(0, 3) == 0);
                rd = !s && ($urandom_range(0, 11) == 0);
                a  = ($urandom_range(0, 99) < ack_pct);
                case ($urandom_range(0, 2))
                    0:       tpc = $urandom;
                    1:       tpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: tpc = 32'($urandom_range(0, 1023));
                endcase
            end
            step(r, s, rd, tpc, a);
        end

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline; it feeds the instruction decoder. It owns the PC, issues one-outstanding-request fetches to instruction memory over a req/ack handshake, and absorbs load-use stalls from the hazard unit with a 1-entry skid buffer. It accepts redirects produced by branch/jump resolution, the decoder's Flush. A redirect squashes the IF/ID entry and any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- NOP, 32'h0000_0013, instruction word driven on instr_o when the IF/ID entry is invalid (addi x0,x0,0)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- imem_req_o  out  1  fetch request; driven only from registers
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1 and no ack
- imem_ack_i  in  1  request accepted; imem_rdata_i valid this cycle; ignored when imem_req_o=0
- imem_rdata_i  in  32  fetched instruction
- stall_i  in  1  hold IF/ID (load-use hazard)
- redirect_i  in  1  squash and refetch (decoder Flush)
- redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0
- valid_o  out  1  IF/ID entry valid
- instr_o  out  32  IF/ID instruction (NOP when valid_o=0)
- pc_o  out  32  IF/ID PC
- pc_plus4_o  out  32  pc_o+4, mod 2^32, for jal/jalr link

## Operation
- State: fetch_pc, target_pc, skid {valid, instr, pc}, IF/ID {valid, instr, pc}, FSM {RST, FETCH, KILL}.
- imem_req_o = (state==FETCH && !skid.valid) || state==KILL. imem_addr_o = fetch_pc.
- Reset (rst_i=0 at edge): state=RST. fetch_pc=RESET_PC. Skid and IF/ID invalid. instr_o=NOP, pc_o=0, imem_req_o=0.
- RST -> FETCH on the first edge with rst_i=1.
- FETCH, ack, no redirect:
  - fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0).
  - If stall_i=0: IF/ID <= {1, rdata, fetch_pc}.
  - If stall_i=1: skid <= {1, rdata, fetch_pc}, and IF/ID holds.
- FETCH, no ack, stall_i=0, skid.valid=1: IF/ID <= skid and skid clears. Skid drains in the same cycle that stall_i drops.
- stall_i=1 with no ack: IF/ID and skid hold.
- Redirect has priority over stall and ack. At the edge:
  - IF/ID.valid=0 and instr=NOP.
  - skid.valid=0.
  - Data from any same-cycle ack is dropped.
- Redirect, next state and PC:
  - Outstanding request with no ack this cycle (imem_req_o=1): target_pc <= redirect_pc_i and state -> KILL. fetch_pc holds to keep the address stable.
  - Otherwise (ack this cycle, or imem_req_o=0): fetch_pc <= redirect_pc_i and state stays FETCH.
- KILL: imem_req_o=1 at the old address.
  - On ack: data dropped, fetch_pc <= target_pc, state -> FETCH.
  - A further redirect in KILL overwrites target_pc and stays in KILL. If it coincides with the ack, the new redirect_pc_i is used.
  - stall_i has no effect in KILL.
- Ack while imem_req_o=0 (e.g. stale response after reset) is ignored.

## Timing
- Fetch-to-decode latency: ack in cycle t -> instr_o/pc_o/valid_o updated in cycle t+1.
- Throughput: 1 instruction/cycle with ack held high and stall_i=0.
- imem_req_o rises in the first cycle after the edge that leaves RST.
- Skid fill: imem_req_o drops the cycle after the ack that fills the skid.
  - Reasserts the cycle after the skid drains, at the next sequential address.
- Redirect in cycle t: valid_o=0 in t+1.
  - Non-KILL path: the new-target request is visible in t+1.
  - KILL path: the new-target request is visible the cycle after the old ack.
- pc_plus4_o is combinational from the pc_o register; no input-to-output combinational paths.

## Test plan
- Reset/stream: RESET_PC=0x100, ack held 1 -> req rises 1 cycle after reset release; instr_o follows rdata with 1-cycle lag; pc_o=0x100,0x104,0x108; pc_plus4_o=0x104,0x108,0x10C.
- Stall with skid: stall_i=1 for 3 cycles while acks continue -> IF/ID holds 0x104, skid takes 0x108, req low for the remainder.
  - On stall drop: pc_o=0x108, then req reissues at 0x10C.
  - No instruction lost or duplicated.
- Redirect concurrent with ack: redirect_i=1, redirect_pc_i=0x203 with ack at 0x110 -> valid_o=0 and instr_o=0x13 next cycle; 0x110 data dropped; next req addr=0x200.
- Redirect during wait (ack delayed 4 cycles): req stays at old addr 0x120 until ack; that data dropped; then req at redirect target 0x300.
  - A second redirect to 0x400 during the wait -> fetch resumes at 0x400.
- Wrap and reset mid-op: fetch at 0xFFFF_FFFC -> next addr 0x0.
  - rst_i=0 during an outstanding request -> next cycle valid_o=0, req=0; late ack ignored; fetch restarts at RESET_PC.
